// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master blocks: FSM states, the
// four quarter-bit phases, and the ACK and R/W bit encodings.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } state_t;

  // Quarter-bit phases, advanced once per tick.
  localparam logic [1:0] PH_LOW    = 2'd0;
  localparam logic [1:0] PH_RISE   = 2'd1;
  localparam logic [1:0] PH_SAMPLE = 2'd2;
  localparam logic [1:0] PH_FALL   = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input such as a raw
// open-drain pin. Resets to RESET_VAL, which is the idle level of the line.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address + R/W, ACK, one data byte, ACK/NACK,
// STOP. Each SCL bit spans four ticks. SCL and SDA are driven as pull-low enables.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              sda_in
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_MSB = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [1:0]        phase;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] shift_q;
  logic [ADDR_W:0]   addr_byte;
  logic              sda_s;
  logic              bit_low;

  sync_2ff #(.RESET_VAL(1'b1)) u_sda_sync (
    .clock (clock),
    .reset (reset),
    .d     (sda_in),
    .q     (sda_s)
  );

  assign addr_byte = {addr_q, rw_q};

  // Level to put on SDA for the current bit: pull low only for a driven 0.
  always_comb begin
    // NOTE: default first so every path assigns bit_low and no latch is inferred.
    bit_low = 1'b0;
    case (state)
      ADDR:    bit_low = ~addr_byte[bit_cnt];
      DATA:    bit_low = (rw_q == RW_WRITE) && !wdata_q[bit_cnt];
      default: bit_low = 1'b0;
    endcase
  end

  // NOTE: request and shift registers carry no reset; they are always loaded
  // before use, so only control state needs a known value after reset.
  always_ff @(posedge clock) begin
    if (state == IDLE && start) begin
      addr_q  <= addr;
      rw_q    <= rw;
      wdata_q <= wdata;
    end
    if (state == DATA && tick && phase == PH_SAMPLE && rw_q == RW_READ)
      shift_q <= {shift_q[DATA_W-2:0], sda_s};
  end

  // NOTE: sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= PH_LOW;
      bit_cnt <= BIT_MSB;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ack_err <= 1'b0;
            busy    <= 1'b1;
            phase   <= PH_LOW;
            bit_cnt <= BIT_MSB;
            state   <= START;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        START: begin
          if (tick) begin
            phase <= phase + 2'd1;
            case (phase)
              PH_LOW:    begin scl_oe <= 1'b0; sda_oe <= 1'b0; end
              PH_RISE:   sda_oe <= 1'b1;
              PH_SAMPLE: ;
              PH_FALL:   begin scl_oe <= 1'b1; state <= ADDR; end
            endcase
          end
        end

        STOP: begin
          if (tick) begin
            phase <= phase + 2'd1;
            case (phase)
              PH_LOW:    begin scl_oe <= 1'b1; sda_oe <= 1'b1; end
              PH_RISE:   scl_oe <= 1'b0;
              PH_SAMPLE: sda_oe <= 1'b0;
              PH_FALL: begin
                if (rw_q == RW_READ && !ack_err) rdata <= shift_q;
                done  <= 1'b1;
                state <= DONE;
              end
            endcase
          end
        end

        // ADDR, ADDR_ACK, DATA, DATA_ACK share the generic four-phase bit.
        default: begin
          if (tick) begin
            phase <= phase + 2'd1;
            case (phase)
              PH_LOW:  begin scl_oe <= 1'b1; sda_oe <= bit_low; end
              PH_RISE: scl_oe <= 1'b0;
              PH_SAMPLE: begin
                if (state == ADDR_ACK && sda_s == I2C_NACK) ack_err <= 1'b1;
                if (state == DATA_ACK && rw_q == RW_WRITE && sda_s == I2C_NACK)
                  ack_err <= 1'b1;
              end
              PH_FALL: begin
                scl_oe <= 1'b1;
                case (state)
                  ADDR, DATA: begin
                    if (bit_cnt == '0) begin
                      bit_cnt <= BIT_MSB;
                      state   <= (state == ADDR) ? ADDR_ACK : DATA_ACK;
                    end else begin
                      bit_cnt <= bit_cnt - 1'b1;
                    end
                  end
                  ADDR_ACK: state <= ack_err ? STOP : DATA;
                  default:  state <= STOP;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: a line-level slave/monitor checks SDA bits at
// SCL rise, START/STOP edges, tick latency and completion status.
module tb_i2c_master_byte;

  logic       clock = 1'b0;
  logic       reset, tick, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, ack_err, scl_oe, sda_oe, sda_in;
  logic       slave_pull = 1'b0;
  logic       scl_line, sda_line;

  // Open-drain bus: the line is low if either master or slave pulls it.
  assign sda_in   = ~(sda_oe | slave_pull);
  assign scl_line = ~scl_oe;
  assign sda_line = sda_in;

  always #5 clock = ~clock;

  i2c_master_byte dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .sda_in  (sda_in)
  );

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] sdata;
    logic       ack_a;
    logic       ack_d;
    bit         align;
    int         glitch;
    logic       exp_err;
    int         exp_ticks;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int tdiv     = 0;

  logic       cfg_rw = 1'b0, cfg_ack_a = 1'b1, cfg_ack_d = 1'b1;
  logic [7:0] cfg_sdata = 8'h00;
  logic [7:0] model_rdata = 8'h00;

  logic [31:0] got_bits = '0;
  int          n_bits = 0, n_start = 0, n_stop = 0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Slave behaviour for bit index k (0-7 address, 8 ack, 9-16 data, 17 ack).
  function automatic logic slave_bit(input int k);
    if (k == 8) return cfg_ack_a;
    if (cfg_ack_a && cfg_rw && k >= 9 && k <= 16) return ~cfg_sdata[16 - k];
    if (cfg_ack_a && !cfg_rw && k == 17) return cfg_ack_d;
    return 1'b0;
  endfunction

  // Bus monitor and slave: record SDA at every SCL rise, count START/STOP,
  // and change the slave's SDA only while SCL is low.
  always @(negedge clock) begin
    if (reset || (start && !busy)) begin
      got_bits   <= '0;
      n_bits     <= 0;
      n_start    <= 0;
      n_stop     <= 0;
      slave_pull <= 1'b0;
    end else begin
      if (!prev_scl && scl_line) begin
        got_bits <= {got_bits[30:0], sda_line};
        n_bits   <= n_bits + 1;
      end
      if (prev_scl && scl_line && prev_sda && !sda_line) n_start <= n_start + 1;
      if (prev_scl && scl_line && !prev_sda && sda_line) n_stop <= n_stop + 1;
      if (prev_scl && !scl_line) slave_pull <= slave_bit(n_bits);
    end
    prev_scl <= scl_line;
    prev_sda <= sda_line;
  end

  // Expected serial stream as seen at SCL rises, including the trailing
  // SCL release in STOP while SDA is still held low.
  function automatic void model(input vec_t v, output logic [31:0] bits, output int nb);
    logic [7:0] ab;
    ab   = {v.addr, v.rw};
    bits = '0;
    nb   = 0;
    for (int i = 7; i >= 0; i--) begin bits = {bits[30:0], ab[i]}; nb++; end
    bits = {bits[30:0], ~v.ack_a}; nb++;
    if (v.ack_a) begin
      for (int i = 7; i >= 0; i--) begin
        bits = {bits[30:0], v.rw ? v.sdata[i] : v.wdata[i]};
        nb++;
      end
      bits = {bits[30:0], v.rw ? 1'b1 : ~v.ack_d}; nb++;
    end
    bits = {bits[30:0], 1'b0}; nb++;
  endfunction

  task automatic step();
    tick = (tdiv % 4 == 3);
    tdiv++;
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [31:0] eb;
    int          enb, n, steps;
    bit          seen;
    model(v, eb, enb);
    cfg_rw = v.rw; cfg_ack_a = v.ack_a; cfg_ack_d = v.ack_d; cfg_sdata = v.sdata;
    if (v.align) begin
      while (tdiv % 4 != 3) step();
    end else if (tdiv % 4 == 3) begin
      step();
    end
    addr = v.addr; rw = v.rw; wdata = v.wdata; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    n = 0; seen = 0;
    for (steps = 0; steps < 2000 && !seen; steps++) begin
      if (steps == v.glitch) begin
        start = 1'b1; addr = ~v.addr; rw = ~v.rw; wdata = ~v.wdata;
      end
      step();
      start = 1'b0;
      if (tick) n++;
      if (done) seen = 1;
    end
    if (v.rw && v.ack_a) model_rdata = v.sdata;
    check({tag, " done_seen"}, seen, 1);
    check({tag, " ticks_to_done"}, n, v.exp_ticks);
    check({tag, " ack_err"}, ack_err, v.exp_err);
    check({tag, " rdata"}, rdata, model_rdata);
    check({tag, " bit_count"}, n_bits, enb);
    check({tag, " sda_bits"}, got_bits, eb);
    check({tag, " start_cond"}, n_start, 1);
    check({tag, " stop_cond"}, n_stop, 1);
    step();
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " busy_cleared"}, busy, 0);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   guard;
    reset = 1'b1; tick = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0;

    // addr, rw, wdata, sdata, ack_a, ack_d, align, glitch, exp_err, exp_ticks
    vecs.push_back('{7'h50, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 0, -1, 1'b0, 80});
    vecs.push_back('{7'h3C, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b1, 0, -1, 1'b0, 80});
    vecs.push_back('{7'h11, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 0, -1, 1'b1, 44});
    vecs.push_back('{7'h22, 1'b0, 8'h0F, 8'h00, 1'b1, 1'b0, 0, -1, 1'b1, 80});
    vecs.push_back('{7'h50, 1'b0, 8'hC3, 8'h00, 1'b1, 1'b1, 0, 30, 1'b0, 80});
    vecs.push_back('{7'h7F, 1'b1, 8'h00, 8'h81, 1'b1, 1'b1, 1, -1, 1'b0, 80});
    for (int i = 0; i < 8; i++) begin
      v.addr  = 7'($urandom);
      v.rw    = 1'($urandom);
      v.wdata = 8'($urandom);
      v.sdata = 8'($urandom);
      v.ack_a = ($urandom_range(0, 3) != 0);
      v.ack_d = ($urandom_range(0, 3) != 0);
      v.align = 1'($urandom);
      v.glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 150)) : -1;
      v.exp_err   = !v.ack_a || (!v.rw && !v.ack_d);
      v.exp_ticks = v.ack_a ? 80 : 44;
      vecs.push_back(v);
    end

    repeat (3) step();
    check("reset scl_oe", scl_oe, 0);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ack_err", ack_err, 0);
    check("reset rdata", rdata, 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset during the data byte: lines drop immediately, no STOP.
    cfg_rw = 1'b0; cfg_ack_a = 1'b1; cfg_ack_d = 1'b1;
    while (tdiv % 4 == 3) step();
    addr = 7'h2A; rw = 1'b0; wdata = 8'h3C; start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (n_bits < 13 && guard < 2000) begin step(); guard++; end
    check("reset_mid reached_data", n_bits >= 13, 1);
    repeat (5) step();
    reset = 1'b1;
    step();
    check("reset_mid scl_oe", scl_oe, 0);
    check("reset_mid sda_oe", sda_oe, 0);
    check("reset_mid busy", busy, 0);
    check("reset_mid done", done, 0);
    reset = 1'b0;
    model_rdata = 8'h00;
    step();
    v = '{7'h2A, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1, 0, -1, 1'b0, 80};
    run_txn(v, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
